// File: rtl/router_pkt_tx_pkg.sv
// Shared router definitions: FSM encoding, header field layout and payload sizing.
// Pure declarations, no logic; imported by the packet source and its FIFO.
package router_pkt_tx_pkg;

  localparam int PAY_W        = 8;
  localparam int MAX_LEN      = 63;
  localparam int LEN_W        = $clog2(MAX_LEN + 1);
  localparam int ADDR_W       = 2;
  localparam int FIFO_DEPTH   = 64;
  localparam int FIFO_CNT_W   = $clog2(FIFO_DEPTH + 1);

  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_LEN_LSB  = 2;

  localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_HEADER    = 3'd2,
    ST_PAYLOAD   = 3'd3,
    ST_PARITY    = 3'd4,
    ST_GAP       = 3'd5
  } state_e;

  function automatic logic [PAY_W-1:0] make_hdr(input logic [ADDR_W-1:0] addr,
                                                input logic [LEN_W-1:0]  len);
    logic [PAY_W-1:0] h;
    h = '0;
    h[HDR_ADDR_LSB +: ADDR_W] = addr;
    h[HDR_LEN_LSB  +: LEN_W]  = len;
    return h;
  endfunction

endpackage

// File: rtl/router_tx_fifo.sv
// 64x8 show-ahead payload FIFO: head byte visible combinationally, count updates one edge after push/pop.
// Pushes while full and pops while empty are ignored; simultaneous push/pop leaves the count unchanged.
module router_tx_fifo
  import router_pkt_tx_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  push,
  input  logic [PAY_W-1:0]      push_dat,
  input  logic                  pop,
  output logic [PAY_W-1:0]      head_dat,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [PAY_W-1:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full     = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
  assign push_ok  = push && !full;
  assign pop_ok   = pop && (count_q != '0);
  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet source: header, buffered payload, parity; header one edge after data is ready.
// All byte hand-offs stall while busy is high; req_ready only in IDLE, pay_ready while the FIFO has room.
module router_pkt_tx
  import router_pkt_tx_pkg::*;
#(
  parameter int IDLE_GAP = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              pay_valid,
  output logic              pay_ready,
  input  logic [PAY_W-1:0]  pay_data,
  input  logic              busy,
  output logic              packet_valid,
  output logic [PAY_W-1:0]  data_in,
  output logic              tx_done,
  output logic              err
);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [PAY_W-1:0]      parity_q, parity_d;
  logic [PAY_W-1:0]      data_q, data_d;
  logic                  pkt_vld_q, pkt_vld_d;
  logic                  tx_done_q, tx_done_d;
  logic                  err_q, err_d;
  logic [3:0]            gap_cnt_q, gap_cnt_d;

  logic                  fifo_pop;
  logic [PAY_W-1:0]      fifo_head;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  fifo_full;
  logic [PAY_W-1:0]      hdr_byte;
  logic                  gap_met;

  router_tx_fifo u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (1'b0),
    .push     (pay_valid),
    .push_dat (pay_data),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full)
  );

  assign req_ready    = (state_q == ST_IDLE);
  assign pay_ready    = !fifo_full;
  assign packet_valid = pkt_vld_q;
  assign data_in      = data_q;
  assign tx_done      = tx_done_q;
  assign err          = err_q;

  assign hdr_byte = make_hdr(addr_q, len_q);
  // Counter saturates at 15, so a 5-bit sum keeps the comparison honest at the top of the range.
  assign gap_met  = (({1'b0, gap_cnt_q} + 5'd1) >= 5'(IDLE_GAP));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    rem_d     = rem_q;
    parity_d  = parity_q;
    data_d    = data_q;
    pkt_vld_d = pkt_vld_q;
    gap_cnt_d = gap_cnt_q;
    tx_done_d = 1'b0;
    err_d     = 1'b0;
    fifo_pop  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_addr == ADDR_ILLEGAL || req_len == '0) begin
            err_d = 1'b1;
          end else begin
            addr_d  = req_addr;
            len_d   = req_len;
            state_d = ST_WAIT_DATA;
          end
        end
      end
      ST_WAIT_DATA: begin
        if (fifo_count >= {1'b0, len_q}) begin
          pkt_vld_d = 1'b1;
          data_d    = hdr_byte;
          parity_d  = hdr_byte;
          state_d   = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (!busy) begin
          fifo_pop = 1'b1;
          data_d   = fifo_head;
          parity_d = parity_q ^ fifo_head;
          rem_d    = len_q - 1'b1;
          state_d  = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (!busy) begin
          if (rem_q != '0) begin
            fifo_pop = 1'b1;
            data_d   = fifo_head;
            parity_d = parity_q ^ fifo_head;
            rem_d    = rem_q - 1'b1;
          end else begin
            pkt_vld_d = 1'b0;
            data_d    = parity_q;
            state_d   = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (!busy) begin
          tx_done_d = 1'b1;
          data_d    = '0;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_met && !busy) begin
          state_d = ST_IDLE;
        end else if (gap_cnt_q != 4'hF) begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      rem_q     <= '0;
      parity_q  <= '0;
      data_q    <= '0;
      pkt_vld_q <= 1'b0;
      tx_done_q <= 1'b0;
      err_q     <= 1'b0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      parity_q  <= parity_d;
      data_q    <= data_d;
      pkt_vld_q <= pkt_vld_d;
      tx_done_q <= tx_done_d;
      err_q     <= err_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: table of requests plus hand-built busy, slow-fill, back-to-back and reset sequences.
module tb_router_pkt_tx;

  localparam int TB_GAP = 2;

  logic       clk = 1'b0;
  logic       resetn;
  logic       req_valid, req_ready;
  logic [1:0] req_addr;
  logic [5:0] req_len;
  logic       pay_valid, pay_ready;
  logic [7:0] pay_data;
  logic       busy;
  logic       packet_valid;
  logic [7:0] data_in;
  logic       tx_done, err;

  always #5 clk = ~clk;

  router_pkt_tx #(.IDLE_GAP(TB_GAP)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .pay_valid    (pay_valid),
    .pay_ready    (pay_ready),
    .pay_data     (pay_data),
    .busy         (busy),
    .packet_valid (packet_valid),
    .data_in      (data_in),
    .tx_done      (tx_done),
    .err          (err)
  );

  typedef struct {
    logic [1:0] addr;
    logic [5:0] len;
    bit         exp_err;
    logic [7:0] b0;
    logic [7:0] step;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] exp_q [$];
  logic [7:0] pay_model_q [$];
  logic [7:0] slow_bytes [63];

  int n_vec = 0, n_bad = 0;
  int pv_cycles = 0, err_cycles = 0, done_cnt = 0;
  int low_run = 0, last_gap = 0;
  bit prev_pv = 0, mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic take(input string name);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: got byte %02h, none expected", name, data_in);
    end else begin
      chk(name, {24'h0, data_in}, {24'h0, exp_q.pop_front()});
    end
  endtask

  // Output monitor, sampled on the falling edge between two active edges.
  task automatic sample();
    if (mon_en) begin
      if (packet_valid) pv_cycles++;
      if (err)          err_cycles++;
      if (tx_done)      done_cnt++;
      if (packet_valid) begin
        if (!prev_pv) last_gap = low_run;
        low_run = 0;
        if (!busy) take("stream_byte");
      end else begin
        low_run++;
        if (prev_pv) take("parity_byte");
      end
    end
    prev_pv = packet_valid;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int k;
    pay_valid = 1'b1;
    pay_data  = b;
    k = 0;
    while (!pay_ready && k < 2000) begin tick(); k++; end
    if (k >= 2000) chk("pay_ready_timeout", 0, 1);
    tick();
    pay_valid = 1'b0;
  endtask

  task automatic preload(input logic [7:0] b);
    pay_model_q.push_back(b);
    push_byte(b);
  endtask

  // Queues the expected header/payload/parity stream, then handshakes the request.
  task automatic request(input logic [1:0] a, input logic [5:0] l);
    logic [7:0] par, b;
    int k;
    if (a != 2'd3 && l != 6'd0) begin
      par = {l, a};
      exp_q.push_back(par);
      for (int i = 0; i < int'(l); i++) begin
        b = pay_model_q.pop_front();
        par ^= b;
        exp_q.push_back(b);
      end
      exp_q.push_back(par);
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    k = 0;
    while (!req_ready && k < 2000) begin tick(); k++; end
    if (k >= 2000) chk("req_ready_timeout", 0, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_cnt < target && k < 3000) begin tick(); k++; end
    chk("tx_done_count", done_cnt, target);
    repeat (TB_GAP + 3) tick();
  endtask

  initial begin
    int p0, e0, d0;
    logic [7:0] b;

    vecs[0] = '{2'd1, 6'd4,  1'b0, 8'h11, 8'h11};
    vecs[1] = '{2'd3, 6'd5,  1'b1, 8'h00, 8'h00};
    vecs[2] = '{2'd0, 6'd0,  1'b1, 8'h00, 8'h00};
    vecs[3] = '{2'd2, 6'd1,  1'b0, 8'hA5, 8'h00};
    vecs[4] = '{2'd0, 6'd7,  1'b0, 8'h3C, 8'h17};
    vecs[5] = '{2'd1, 6'd16, 1'b0, 8'hF0, 8'h09};

    resetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0;
    pay_valid = 1'b0; pay_data = '0; busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_packet_valid", packet_valid, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_err", err, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_pay_ready", pay_ready, 1);
    resetn = 1'b1;
    mon_en = 1'b1;

    for (int v = 0; v < 6; v++) begin
      if (!vecs[v].exp_err)
        for (int i = 0; i < int'(vecs[v].len); i++) preload(8'(vecs[v].b0 + i * vecs[v].step));
      p0 = pv_cycles; e0 = err_cycles; d0 = done_cnt;
      request(vecs[v].addr, vecs[v].len);
      if (vecs[v].exp_err) begin
        chk("err_pulse", err, 1);
        chk("err_stays_idle", req_ready, 1);
        repeat (4) tick();
      end else begin
        tick();
        chk("hdr_latency_pv", packet_valid, 1);
        chk("hdr_latency_byte", data_in, {vecs[v].len, vecs[v].addr});
        wait_done(d0 + 1);
      end
      chk("err_cycles", err_cycles - e0, vecs[v].exp_err ? 1 : 0);
      chk("done_pulses", done_cnt - d0, vecs[v].exp_err ? 0 : 1);
      chk("pv_cycles", pv_cycles - p0, vecs[v].exp_err ? 0 : int'(vecs[v].len) + 1);
    end

    // Router stalls for 3 cycles while the second payload byte is presented.
    for (int i = 0; i < 4; i++) preload(8'(8'h11 * (i + 1)));
    p0 = pv_cycles; d0 = done_cnt;
    request(2'd1, 6'd4);
    repeat (3) tick();
    chk("busy_byte_before", data_in, 8'h22);
    busy = 1'b1;
    repeat (3) tick();
    chk("busy_byte_held", data_in, 8'h22);
    chk("busy_pv_held", packet_valid, 1);
    busy = 1'b0;
    wait_done(d0 + 1);
    chk("busy_pv_cycles", pv_cycles - p0, 8);

    // Two queued requests sharing one preloaded burst.
    for (int i = 0; i < 5; i++) preload(8'(8'hC1 + 8'(i * 3)));
    p0 = pv_cycles; d0 = done_cnt;
    request(2'd0, 6'd2);
    request(2'd2, 6'd3);
    wait_done(d0 + 2);
    chk("b2b_pv_cycles", pv_cycles - p0, 7);
    chk("b2b_idle_gap_ok", (last_gap >= TB_GAP + 1) ? 1 : 0, 1);

    // Maximum length with a slow trickle of payload: no header until all 63 bytes are in.
    for (int i = 0; i < 63; i++) begin
      slow_bytes[i] = 8'($urandom_range(0, 255));
      pay_model_q.push_back(slow_bytes[i]);
    end
    p0 = pv_cycles; d0 = done_cnt;
    request(2'd2, 6'd63);
    for (int i = 0; i < 63; i++) begin
      pay_valid = 1'b1;
      pay_data  = slow_bytes[i];
      tick();
      pay_valid = 1'b0;
      if (i < 62) tick();
    end
    chk("slow_no_early_hdr", pv_cycles - p0, 0);
    chk("slow_pv_low", packet_valid, 0);
    wait_done(d0 + 1);
    chk("slow_pv_cycles", pv_cycles - p0, 64);

    // Reset in the middle of a payload, then a clean packet.
    for (int i = 0; i < 6; i++) preload(8'(8'h60 + i));
    request(2'd0, 6'd6);
    repeat (3) tick();
    chk("pre_rst_in_payload", packet_valid, 1);
    mon_en = 1'b0;
    resetn = 1'b0;
    tick();
    chk("mid_rst_pv", packet_valid, 0);
    chk("mid_rst_data", data_in, 0);
    chk("mid_rst_pay_ready", pay_ready, 1);
    chk("mid_rst_req_ready", req_ready, 1);
    resetn = 1'b1;
    exp_q.delete();
    pay_model_q.delete();
    repeat (2) tick();
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b = 8'(8'h9A ^ (i * 8'h21));
      preload(b);
    end
    p0 = pv_cycles; d0 = done_cnt;
    request(2'd1, 6'd3);
    wait_done(d0 + 1);
    chk("post_rst_pv_cycles", pv_cycles - p0, 4);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet source for the router 1x3 input port. Accepts a packet request (destination address plus payload length) and a payload byte stream from upstream. Buffers the payload so it can be sent back-to-back. Drives `packet_valid` and `data_in` into the router as header, payload and parity, obeying the router's `busy` back-pressure. Sits between test/host traffic logic and the router top-level input.

## Interface
Parameters:
- `IDLE_GAP`, default 1: minimum idle cycles with `packet_valid` = 0 between the end of one packet and the next header (range 1..15).

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset; synchronous, active-low. Clock is `clk`.
- `req_valid`  in  1  packet request valid.
- `req_ready`  out  1  request accepted when both valid and ready are high at a rising edge.
- `req_addr`  in  2  destination port; 3 is illegal.
- `req_len`  in  6  payload length in bytes; 0 is illegal.
- `pay_valid`  in  1  payload byte valid.
- `pay_ready`  out  1  payload FIFO not full.
- `pay_data`  in  8  payload byte.
- `busy`  in  1  router busy; a byte is taken only at an edge where `busy` = 0.
- `packet_valid`  out  1  to the router; high during header and payload.
- `data_in`  out  8  to the router; header, payload or parity byte.
- `tx_done`  out  1  one-cycle pulse when parity is taken.
- `err`  out  1  one-cycle pulse when an illegal request is rejected.

## Operation
- Header byte = {len[5:0], addr[1:0]}.
- Parity = XOR of the header byte and all payload bytes.
- Payload path: 64x8 show-ahead FIFO; push on `pay_valid && pay_ready`. Bytes beyond the current `len` stay in the FIFO for later packets.
- FSM states: IDLE, WAIT_DATA, HEADER, PAYLOAD, PARITY, GAP.
- IDLE:
  - `req_ready` = 1.
  - On accept with addr = 3 or len = 0: pulse `err`, stay in IDLE.
  - On any other accept: latch addr/len, go to WAIT_DATA.
- WAIT_DATA:
  - Hold until FIFO count ≥ len.
  - Then register `packet_valid` = 1, `data_in` = header, parity = header, go to HEADER.
- HEADER:
  - Hold outputs while `busy` = 1.
  - At the first edge with `busy` = 0: pop the FIFO head onto `data_in`, XOR it into parity, set remaining = len−1, go to PAYLOAD.
- PAYLOAD:
  - At each edge with `busy` = 0 and remaining > 0: pop the next byte, XOR it into parity, decrement remaining.
  - At the edge with `busy` = 0 and remaining = 0: `packet_valid` ← 0, `data_in` ← parity, go to PARITY.
  - While `busy` = 1: hold all outputs (router FIFO-full case).
- PARITY:
  - At the first edge with `busy` = 0: pulse `tx_done`, `data_in` ← 0, go to GAP.
- GAP:
  - Stay at least `IDLE_GAP` cycles and until `busy` = 0, then go to IDLE.
- FIFO:
  - Simultaneous push and pop is allowed; count stays unchanged.
  - Pop never happens on an empty FIFO, because WAIT_DATA guarantees the bytes are present.

## Timing
- Reset values: FSM in IDLE, FIFO empty, `packet_valid` = 0, `data_in` = 8'h00, `tx_done` = 0, `err` = 0, `req_ready` = 1, `pay_ready` = 1.
- `packet_valid`, `data_in`, `tx_done` and `err` are registered.
- `req_ready` and `pay_ready` are decoded combinationally from state and count.
- Latency: request accepted at edge N with the FIFO already holding ≥ len bytes gives the header on `data_in` after edge N+1.
- With `busy` = 0 throughout, a packet of length L occupies L+1 cycles with `packet_valid` high, then one parity cycle.
- Reset mid-packet:
  - `packet_valid` is 0 after the reset edge.
  - The FIFO is flushed and the latched request is dropped.
  - Recovering the truncated packet is the router's responsibility (soft reset).
- `err` and an accept can never happen in the same cycle as a packet in flight, because `req_ready` is 0 outside IDLE.

## Structure
- Shared router package holds:
  - state encoding constants;
  - the address-3 illegal constant;
  - the header-byte field positions;
  - the payload width (8) and maximum length (63).
- Sub-module: `router_tx_fifo` (64x8 show-ahead FIFO with 7-bit count, push/pop/flush).

## Test plan
- addr = 1, len = 4, payload 11, 22, 33, 44 preloaded, `busy` = 0:
  - `data_in` sequence 8'h11 header, 11, 22, 33, 44 with `packet_valid` high;
  - then parity 8'h55 with `packet_valid` low;
  - `tx_done` pulses once.
- Same packet with `busy` forced high for 3 cycles during the second payload byte: byte 22 is held 3 extra cycles; no byte lost or duplicated.
- Request addr = 3, len = 5: `err` pulses for 1 cycle, `packet_valid` stays 0, FSM returns to IDLE. Repeat with len = 0: same result.
- len = 63 with payload streamed slowly (1 byte per 2 cycles): header is not driven until 63 bytes are buffered; then 63 bytes go out back-to-back.
- Two back-to-back requests (len 2 then len 3, 5 bytes preloaded): gap of at least `IDLE_GAP` cycles between the first parity and the second header.
- `resetn` low during PAYLOAD:
  - next cycle `packet_valid` = 0, `data_in` = 0, `pay_ready` = 1;
  - a new request then transmits correctly.
